// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read arbiter.
// Holds the arbiter state encoding and a helper that sizes the requester id tag.
package spi_flash_pkg;

    localparam logic [7:0] FLASH_READ_OPCODE = 8'h03;
    localparam int         FLASH_ADDR_W      = 24;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        STREAM,
        DRAIN,
        ZERO
    } arb_state_t;

    // Id tag width never drops below one bit, even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Client-side bundle of the arbiter: packed read commands in, tagged byte responses out.
// The master modport is the client fabric; the slave modport is the arbiter.
interface spi_flash_arbiter_if
    import spi_flash_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = FLASH_ADDR_W,
    parameter int LEN_W   = 16,
    parameter int ID_W    = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      rsp_valid;
    logic [7:0]                rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_last;
    logic                      rsp_err;

    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
    );

endinterface

// File: rtl/spi_flash_arbiter_rr_pick.sv
// Combinational one-hot winner select. SPI_ARB_ROUND_ROBIN_EN selects rotating
// priority starting after ptr; otherwise the lowest set index always wins.
module rr_pick
    import spi_flash_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef SPI_ARB_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search so no path leaves
        // it unassigned, which would otherwise infer a latch.
        grant    = '0;
        grant_id = '0;
        idx      = 0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        // Walk from the farthest offset inward so the nearest requester after ptr wins.
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash byte-read engine between NUM_REQ clients and streams tagged
// bytes back. SPI_ARB_ROUND_ROBIN_EN enables rotating priority (fixed otherwise).
module spi_flash_arbiter
    import spi_flash_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = FLASH_ADDR_W,
    parameter int LEN_W   = 16,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    spi_flash_arbiter_if.slave   bus,
    output logic                 eng_start,
    output logic [ADDR_W-1:0]    eng_addr,
    output logic [LEN_W-1:0]     eng_len,
    input  logic                 eng_busy,
    input  logic                 eng_byte_valid,
    input  logic [7:0]           eng_byte,
    output logic                 busy
);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic [LEN_W-1:0]   remaining;
    logic               accept;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]    ptr;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req      (bus.req_valid),
`ifdef SPI_ARB_ROUND_ROBIN_EN
        .ptr      (ptr),
`endif
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign sel_addr = bus.req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    assign sel_len  = bus.req_len[int'(grant_id)*LEN_W +: LEN_W];
    assign accept   = (state == IDLE) && (|bus.req_valid);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (accept) state_nxt = (sel_len == '0) ? ZERO : ISSUE;
            ISSUE:  if (eng_busy) state_nxt = STREAM;
            STREAM: begin
                if (eng_byte_valid && remaining == LEN_W'(1)) state_nxt = DRAIN;
                else if (!eng_byte_valid && !eng_busy)        state_nxt = IDLE;
            end
            DRAIN:  if (!eng_busy) state_nxt = IDLE;
            ZERO:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) ? grant : '0;
        eng_start     = (state == ISSUE);
        busy          = (state != IDLE);
    end

    // Response registers pulse for a single cycle; a zero-length command
    // produces its completion directly from the accept edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            eng_addr      <= '0;
            eng_len       <= '0;
            remaining     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_last  <= 1'b0;
            bus.rsp_err   <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            ptr           <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_last  <= 1'b0;
            bus.rsp_err   <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    eng_addr   <= sel_addr;
                    eng_len    <= sel_len;
                    bus.rsp_id <= grant_id;
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    ptr        <= grant_id;
`endif
                    if (sel_len == '0) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_last  <= 1'b1;
                    end
                end
                ISSUE: if (eng_busy) remaining <= eng_len;
                STREAM: begin
                    if (eng_byte_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= eng_byte;
                        bus.rsp_last  <= (remaining == LEN_W'(1));
                        remaining     <= remaining - LEN_W'(1);
                    end else if (!eng_busy) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_last  <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter; expectations follow SPI_ARB_ROUND_ROBIN_EN
// when it is defined for the build.
module tb_spi_flash_arbiter;
    import spi_flash_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 24;
    localparam int LEN_W   = 16;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              n_rst;
    logic              eng_start;
    logic [ADDR_W-1:0] eng_addr;
    logic [LEN_W-1:0]  eng_len;
    logic              eng_busy;
    logic              eng_byte_valid;
    logic [7:0]        eng_byte;
    logic              busy;

    int total = 0;
    int bad   = 0;

    spi_flash_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    spi_flash_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .bus            (bus),
        .eng_start      (eng_start),
        .eng_addr       (eng_addr),
        .eng_len        (eng_len),
        .eng_busy       (eng_busy),
        .eng_byte_valid (eng_byte_valid),
        .eng_byte       (eng_byte),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Response packed as {valid, last, err, id, data}.
    function automatic logic [11:0] rsp_vec();
        return {bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.rsp_id, bus.rsp_data};
    endfunction

    function automatic logic [11:0] exp_rsp(input logic v, input logic l, input logic e,
                                            input logic id, input logic [7:0] d);
        return {v, l, e, id, d};
    endfunction

    task automatic set_req(input int i, input logic [23:0] a, input logic [15:0] l);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_len[i*LEN_W +: LEN_W]    = l;
    endtask

    // Strobe one byte for one cycle; returns on the negedge after it was sampled.
    task automatic pulse_byte(input logic [7:0] b);
        eng_byte       = b;
        eng_byte_valid = 1'b1;
        @(negedge clk);
        eng_byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        n_rst          = 1'b0;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        eng_busy       = 1'b0;
        eng_byte_valid = 1'b0;
        eng_byte       = '0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL reset_eng_start got=%b exp=0", eng_start); end
        total++; if ({eng_addr, eng_len} !== '0) begin bad++; $display("FAIL reset_eng_cmd got=%h/%h exp=0/0", eng_addr, eng_len); end
        total++; if (rsp_vec() !== 12'h000) begin bad++; $display("FAIL reset_rsp got=%h exp=000", rsp_vec()); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
    endtask

    task automatic test_contention();
        set_req(0, 24'h001000, 16'd1);
        set_req(1, 24'h002000, 16'd1);
        bus.req_valid = 2'b11;
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL cont_first_ready got=%b exp=01", bus.req_ready); end
        @(negedge clk);
        total++; if (eng_addr !== 24'h001000) begin bad++; $display("FAIL cont_first_addr got=%h exp=001000", eng_addr); end
        eng_busy = 1'b1;
        @(negedge clk);
        pulse_byte(8'h11);
        total++; if (rsp_vec() !== exp_rsp(1, 1, 0, 0, 8'h11)) begin bad++; $display("FAIL cont_first_rsp got=%h exp=%h", rsp_vec(), exp_rsp(1, 1, 0, 0, 8'h11)); end
        eng_busy = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus.req_ready !== (RR ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_second_ready got=%b exp=%b", bus.req_ready, RR ? 2'b10 : 2'b01); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        total++; if (eng_addr !== (RR ? 24'h002000 : 24'h001000)) begin bad++; $display("FAIL cont_second_addr got=%h", eng_addr); end
        eng_busy = 1'b1;
        @(negedge clk);
        pulse_byte(8'h22);
        total++; if (rsp_vec() !== exp_rsp(1, 1, 0, RR, 8'h22)) begin bad++; $display("FAIL cont_second_rsp got=%h exp=%h", rsp_vec(), exp_rsp(1, 1, 0, RR, 8'h22)); end
        eng_busy = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        logic [7:0] b;
        set_req(0, 24'h000100, 16'd4);
        bus.req_valid = 2'b01;
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        total++; if ({eng_start, busy, eng_addr, eng_len} !== {1'b1, 1'b1, 24'h000100, 16'd4}) begin
            bad++; $display("FAIL single_issue got=%b%b %h %h exp=11 000100 0004", eng_start, busy, eng_addr, eng_len);
        end
        eng_busy = 1'b1;
        @(negedge clk);
        total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL single_start_drop got=%b exp=0", eng_start); end
        for (int i = 0; i < 4; i++) begin
            b = 8'hA0 + 8'(i);
            pulse_byte(b);
            total++; if (rsp_vec() !== exp_rsp(1, i == 3, 0, 0, b)) begin bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, rsp_vec(), exp_rsp(1, i == 3, 0, 0, b)); end
        end
        eng_busy = 1'b0;
        @(negedge clk);
        total++; if ({bus.rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_done got=%b%b exp=00", bus.rsp_valid, busy); end
    endtask

    task automatic test_zero_len();
        set_req(1, 24'h000555, 16'd0);
        bus.req_valid = 2'b10;
        #1;
        total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL zero_ready got=%b exp=10", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        total++; if (rsp_vec() !== exp_rsp(1, 1, 0, 1, 8'h00)) begin bad++; $display("FAIL zero_rsp got=%h exp=%h", rsp_vec(), exp_rsp(1, 1, 0, 1, 8'h00)); end
        total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL zero_start got=%b exp=0", eng_start); end
        @(negedge clk);
        total++; if ({bus.rsp_valid, busy, eng_start} !== 3'b000) begin bad++; $display("FAIL zero_done got=%b%b%b exp=000", bus.rsp_valid, busy, eng_start); end
    endtask

    task automatic test_short_engine();
        logic [7:0] b;
        set_req(0, 24'h000300, 16'd8);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        eng_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            b = 8'h50 + 8'(i);
            pulse_byte(b);
            total++; if (rsp_vec() !== exp_rsp(1, 0, 0, 0, b)) begin bad++; $display("FAIL short_byte%0d got=%h exp=%h", i, rsp_vec(), exp_rsp(1, 0, 0, 0, b)); end
        end
        eng_busy = 1'b0;
        @(negedge clk);
        total++; if (rsp_vec() !== exp_rsp(1, 1, 1, 0, 8'h00)) begin bad++; $display("FAIL short_err got=%h exp=%h", rsp_vec(), exp_rsp(1, 1, 1, 0, 8'h00)); end
        set_req(1, 24'h000000, 16'd0);
        bus.req_valid = 2'b10;
        #1;
        total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL short_next_ready got=%b exp=10", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        total++; if (rsp_vec() !== exp_rsp(1, 1, 0, 1, 8'h00)) begin bad++; $display("FAIL short_next_rsp got=%h exp=%h", rsp_vec(), exp_rsp(1, 1, 0, 1, 8'h00)); end
        @(negedge clk);
    endtask

    task automatic test_coincident();
        set_req(0, 24'h000400, 16'd2);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        eng_busy = 1'b1;
        @(negedge clk);
        pulse_byte(8'h61);
        total++; if (rsp_vec() !== exp_rsp(1, 0, 0, 0, 8'h61)) begin bad++; $display("FAIL coin_first got=%h exp=%h", rsp_vec(), exp_rsp(1, 0, 0, 0, 8'h61)); end
        eng_busy = 1'b0;
        pulse_byte(8'h62);
        total++; if (rsp_vec() !== exp_rsp(1, 1, 0, 0, 8'h62)) begin bad++; $display("FAIL coin_last got=%h exp=%h", rsp_vec(), exp_rsp(1, 1, 0, 0, 8'h62)); end
        @(negedge clk);
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL coin_no_err got=%b exp=0", bus.rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL coin_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_stream();
        set_req(0, 24'h000600, 16'd6);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        eng_busy = 1'b1;
        @(negedge clk);
        pulse_byte(8'h71);
        pulse_byte(8'h72);
        total++; if (rsp_vec() !== exp_rsp(1, 0, 0, 0, 8'h72)) begin bad++; $display("FAIL rst_pre got=%h exp=%h", rsp_vec(), exp_rsp(1, 0, 0, 0, 8'h72)); end
        #2;
        n_rst = 1'b0;
        #1;
        total++; if ({busy, eng_start} !== 2'b00) begin bad++; $display("FAIL rst_async_ctl got=%b%b exp=00", busy, eng_start); end
        total++; if (rsp_vec() !== 12'h000) begin bad++; $display("FAIL rst_async_rsp got=%h exp=000", rsp_vec()); end
        total++; if ({eng_addr, eng_len} !== '0) begin bad++; $display("FAIL rst_async_cmd got=%h/%h exp=0/0", eng_addr, eng_len); end
        eng_busy = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        set_req(1, 24'h000700, 16'd1);
        bus.req_valid = 2'b11;
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant got=%b exp=01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_zero_len();
        test_short_engine();
        test_coincident();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares one byte-level SPI flash read engine between NUM_REQ requesters, e.g. bootstrap loader, config fetcher and runtime user reads.
- Each requester posts a read command (24-bit flash address, byte length).
- The arbiter grants one requester, launches the engine, and streams the returned bytes back tagged with the requester id.
- Sits between the flash-read engine (which owns f_sclk/f_cs/f_mosi/f_miso) and the fabric clients.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 24, flash byte address width
- LEN_W, 16, transfer length width in bytes
- ID_W, $clog2(NUM_REQ) (minimum 1), width of requester id tag

Ports:
- clk  in  1  system clock; single clock domain, all logic on posedge
- n_rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester command pending; held until accepted
- req_addr  in  NUM_REQ*ADDR_W  packed start addresses; slice i belongs to requester i
- req_len  in  NUM_REQ*LEN_W  packed byte counts
- req_ready  out  NUM_REQ  one-hot accept strobe; command i is consumed on the clk edge where req_valid[i] & req_ready[i]
- eng_start  out  1  launch request to engine; level, held until eng_busy is seen high
- eng_addr  out  ADDR_W  latched address presented to engine
- eng_len  out  LEN_W  latched length presented to engine
- eng_busy  in  1  engine transaction in progress (f_cs low)
- eng_byte_valid  in  1  one-cycle strobe per received byte
- eng_byte  in  8  received byte
- rsp_valid  out  1  byte (or zero-length completion) delivered
- rsp_data  out  8  byte data
- rsp_id  out  ID_W  owning requester
- rsp_last  out  1  final response of the transfer
- rsp_err  out  1  engine dropped busy before len bytes arrived; qualified by rsp_valid
- busy  out  1  arbiter not IDLE

Behaviour:
- Reset (async, n_rst low):
  - state=IDLE.
  - All outputs 0; eng_addr/eng_len = 0.
  - Remaining-byte counter = 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transfer abandons the transfer silently; the engine is expected to share n_rst.
- States: IDLE, ISSUE, STREAM, DRAIN, ZERO.
- IDLE:
  - If any req_valid, winner w = first set bit searching upward from pointer+1 with wrap.
  - req_ready[w]=1 combinationally in that cycle only.
  - On the edge: latch addr/len/id, pointer<=w.
  - If len==0, go to ZERO; else ISSUE.
  - Latency from req_valid rising to accept: 0 cycles if idle.
- ZERO: one cycle with rsp_valid=1, rsp_last=1, rsp_data=0, rsp_err=0; then IDLE. The engine is never started.
- ISSUE:
  - eng_start=1 with eng_addr/eng_len stable.
  - When eng_busy=1 is sampled: eng_start<=0, remaining<=len, go to STREAM.
- STREAM, on each eng_byte_valid:
  - rsp_valid=1 next cycle (registered, 1-cycle latency), rsp_data=eng_byte, rsp_id=latched id.
  - remaining decrements.
  - rsp_last=1 on the byte where remaining was 1; then go to DRAIN.
- STREAM, eng_busy falls with remaining>0:
  - Emit one response with rsp_valid=rsp_last=rsp_err=1, rsp_data=0.
  - Go IDLE.
  - If eng_byte_valid coincides with the busy fall, the byte is emitted first and the error response follows the next cycle.
- DRAIN:
  - Wait for eng_busy=0, then IDLE.
  - Extra eng_byte_valid pulses in DRAIN are discarded.
- Responses are never back-pressured; clients must accept at byte rate.
- Back-to-back: a new grant is possible the cycle after returning to IDLE.
- Remaining counter is LEN_W bits; len=2^LEN_W-1 is the maximum.

Optional Feature:
- Macro: SPI_ARB_ROUND_ROBIN_EN.
- Defined: rotating priority as described above.
- Undefined: fixed priority, lowest index always wins; RR pointer logic is removed and req 0 can starve others.

Decomposition:
- Package spi_flash_pkg holds:
  - FLASH_READ_OPCODE = 8'h03
  - FLASH_ADDR_W = 24
  - arb_state_t enum (IDLE, ISSUE, STREAM, DRAIN, ZERO)
- Sub-module rr_pick (NUM_REQ): combinational one-hot winner from req vector and pointer; contains the macro-selected fixed-priority variant.

Test Plan:
- Single request: req0 addr=0x000100, len=4; engine returns A0..A3 → four rsp_valid with rsp_id=0, rsp_last only on A3; busy low after eng_busy falls.
- Contention: req0 and req1 valid simultaneously from reset → req0 granted first; if req0 reasserts immediately, req1 is granted next (RR). Without the macro, req0 is granted twice.
- Zero length: req1 len=0 → one rsp_valid with rsp_last=1, rsp_err=0; eng_start never asserted.
- Short engine: len=8, engine drops busy after 5 bytes → 5 data responses then one rsp_err=1, rsp_last=1 response; next request is accepted.
- Reset mid-STREAM (after 2 of 6 bytes) → all outputs 0 asynchronously; first grant after release goes to req0.
- Coincident last byte and busy fall with remaining=1 → a normal rsp_last with no error response.
